// File: rtl/cook_program_scheduler_pkg.sv
// Shared constants, types and small helpers for the cooking program scheduler.
package cook_program_scheduler_pkg;

  localparam int MIN_W      = 4;
  localparam int SEC_W      = 6;
  localparam int PWR_W      = 4;
  localparam int SLOT_W     = 4;
  localparam int MAX_STAGES = 4;
  localparam int DUTY_SLOTS = 10;

  localparam logic [PWR_W-1:0] MAX_PWR = 4'd10;
  localparam logic [SEC_W-1:0] MAX_SEC = 6'd59;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [MIN_W-1:0] mins;
    logic [SEC_W-1:0] secs;
    logic [PWR_W-1:0] pwr;
  } stage_entry_t;

  localparam stage_entry_t ENTRY_ZERO = '{mins: 4'd0, secs: 6'd0, pwr: 4'd0};

  // Seconds above 59 are stored as 59.
  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] s);
    return (s > MAX_SEC) ? MAX_SEC : s;
  endfunction

  // Power above 10 is stored as 10.
  function automatic logic [PWR_W-1:0] clamp_pwr(input logic [PWR_W-1:0] p);
    return (p > MAX_PWR) ? MAX_PWR : p;
  endfunction

  // A stage takes part in the program only when its time is not 0:00.
  function automatic logic entry_live(input stage_entry_t e);
    return (e.mins != 4'd0) || (e.secs != 6'd0);
  endfunction

endpackage

// File: rtl/cook_program_scheduler_sec_tick_gen.sv
// One-second tick divider plus the 0..9 duty slot counter used for power cycling.
module cook_program_scheduler_sec_tick_gen
  import cook_program_scheduler_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              run,
  input  logic              restart,
  output logic              sec_tick,
  output logic [SLOT_W-1:0] slot
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DUTY_SLOTS - 1);

  logic [TICK_W-1:0] tick_cnt_r;
  logic [SLOT_W-1:0] slot_r;
  logic              tick_wrap_s;

  assign tick_wrap_s = run && (tick_cnt_r == TICK_LAST);
  assign sec_tick    = tick_wrap_s;
  assign slot        = slot_r;

  // Tick counter: cleared on stage load, counts only while running, holds otherwise.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else if (restart) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else if (run) begin
      tick_cnt_r <= tick_wrap_s ? {TICK_W{1'b0}} : tick_cnt_r + 1'b1;
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  // Duty slot: advances once per second and wraps after the tenth slot.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      slot_r <= 4'd0;
    end else if (restart) begin
      slot_r <= 4'd0;
    end else if (tick_wrap_s) begin
      slot_r <= (slot_r == SLOT_LAST) ? 4'd0 : slot_r + 4'd1;
    end else begin
      slot_r <= slot_r;
    end
  end

endmodule

// File: rtl/cook_program_scheduler.sv
// Multi-stage cooking program sequencer: stage store, start edge detect,
// control FSM and door-gated magnetron drive.
module cook_program_scheduler
  import cook_program_scheduler_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int TICK_DIV = 100
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             prog_we,
  input  logic [1:0]       prog_idx,
  input  logic [MIN_W-1:0] prog_min,
  input  logic [SEC_W-1:0] prog_sec,
  input  logic [PWR_W-1:0] prog_pwr,
  input  logic             startn,
  input  logic             stopn,
  input  logic             door_closed,
  input  logic             timer_zero,
  output logic             timer_load,
  output logic [MIN_W-1:0] timer_min,
  output logic [SEC_W-1:0] timer_sec,
  output logic             timer_en,
  output logic             sec_tick,
  output logic             mag_on,
  output logic [1:0]       stage,
  output logic             busy,
  output logic             done
);

  state_t            state_r, state_nxt_s;
  logic [1:0]        stage_r, stage_nxt_s;
  logic              startn_q_r;
  stage_entry_t      prog_mem_r [MAX_STAGES];
  stage_entry_t      eff_mem_s  [MAX_STAGES];
  stage_entry_t      wr_entry_s;
  stage_entry_t      cur_entry_s;
  logic              wr_en_s;
  logic              start_evt_s;
  logic              any_live_s;
  logic [1:0]        first_live_s;
  logic              has_next_s;
  logic [1:0]        next_live_s;
  logic              load_s, run_s, busy_s, done_s;
  logic              tick_s;
  logic [SLOT_W-1:0] slot_s;

  assign start_evt_s = startn_q_r & ~startn;
  assign wr_en_s     = (state_r == ST_IDLE) && prog_we && (int'(prog_idx) < STAGES);
  assign cur_entry_s = prog_mem_r[stage_r];

  // Incoming entry with out-of-range seconds and power saturated.
  always_comb begin
    wr_entry_s      = ENTRY_ZERO;
    wr_entry_s.mins = prog_min;
    wr_entry_s.secs = clamp_sec(prog_sec);
    wr_entry_s.pwr  = clamp_pwr(prog_pwr);
  end

  // Stage store: written only in IDLE; slots beyond STAGES stay empty forever.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < MAX_STAGES; i++) prog_mem_r[i] <= ENTRY_ZERO;
    end else begin
      for (int i = 0; i < MAX_STAGES; i++) begin
        if (wr_en_s && (prog_idx == 2'(i))) prog_mem_r[i] <= wr_entry_s;
        else                                prog_mem_r[i] <= prog_mem_r[i];
      end
    end
  end

  // First live stage, seen through a same-cycle write so a write issued with start counts.
  always_comb begin
    any_live_s   = 1'b0;
    first_live_s = 2'd0;
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      eff_mem_s[i] = (wr_en_s && (prog_idx == 2'(i))) ? wr_entry_s : prog_mem_r[i];
      any_live_s   = any_live_s | entry_live(eff_mem_s[i]);
      first_live_s = entry_live(eff_mem_s[i]) ? 2'(i) : first_live_s;
    end
  end

  // Lowest live stage above the current one; empty slots are skipped.
  always_comb begin
    has_next_s  = 1'b0;
    next_live_s = 2'd0;
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      has_next_s  = has_next_s | (entry_live(prog_mem_r[i]) && (2'(i) > stage_r));
      next_live_s = (entry_live(prog_mem_r[i]) && (2'(i) > stage_r)) ? 2'(i) : next_live_s;
    end
  end

  // Start button history for falling-edge detection.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) startn_q_r <= 1'b1;
    else       startn_q_r <= startn;
  end

  // FSM state and current stage index.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_r <= ST_IDLE;
      stage_r <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      stage_r <= stage_nxt_s;
    end
  end

  // Next-state logic; stop outranks door open, which outranks timer_zero and start.
  always_comb begin
    state_nxt_s = state_r;
    stage_nxt_s = stage_r;
    case (state_r)
      ST_IDLE: begin
        if (start_evt_s && door_closed && any_live_s) begin
          state_nxt_s = ST_LOAD;
          stage_nxt_s = first_live_s;
        end else begin
          state_nxt_s = ST_IDLE;
          stage_nxt_s = 2'd0;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (!stopn || !door_closed) begin
          state_nxt_s = ST_PAUSE;
        end else if (timer_zero && has_next_s) begin
          state_nxt_s = ST_LOAD;
          stage_nxt_s = next_live_s;
        end else if (timer_zero) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (!stopn) begin
          state_nxt_s = ST_IDLE;
          stage_nxt_s = 2'd0;
        end else if (start_evt_s && door_closed) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (!stopn || !door_closed || start_evt_s) begin
          state_nxt_s = ST_IDLE;
          stage_nxt_s = 2'd0;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        stage_nxt_s = 2'd0;
      end
    endcase
  end

  // Moore output decode from the state register.
  always_comb begin
    load_s = 1'b0;
    run_s  = 1'b0;
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      ST_IDLE:  busy_s = 1'b0;
      ST_LOAD:  begin load_s = 1'b1; busy_s = 1'b1; end
      ST_RUN:   begin run_s  = 1'b1; busy_s = 1'b1; end
      ST_PAUSE: busy_s = 1'b1;
      ST_DONE:  done_s = 1'b1;
      default:  busy_s = 1'b0;
    endcase
  end

  cook_program_scheduler_sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_sec_tick_gen (
    .clk      (clk),
    .clear    (clear),
    .run      (run_s),
    .restart  (load_s),
    .sec_tick (tick_s),
    .slot     (slot_s)
  );

  assign timer_load = load_s;
  assign timer_min  = load_s ? cur_entry_s.mins : {MIN_W{1'b0}};
  assign timer_sec  = load_s ? cur_entry_s.secs : {SEC_W{1'b0}};
  assign timer_en   = run_s;
  assign sec_tick   = tick_s;
  assign stage      = stage_r;
  assign busy       = busy_s;
  assign done       = done_s;
  // Door gating is combinational so the magnetron drops the instant the door opens.
  assign mag_on     = (slot_s < cur_entry_s.pwr) & door_closed & run_s;

endmodule

// File: tb/tb_cook_program_scheduler.sv
// Scoreboard bench: stimulus pushes expected loads/done and per-stage duty
// statistics; an independent monitor pops them when the DUT presents events.
module tb_cook_program_scheduler;

  localparam int STAGES   = 3;
  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       clear;
  logic       prog_we;
  logic [1:0] prog_idx;
  logic [3:0] prog_min;
  logic [5:0] prog_sec;
  logic [3:0] prog_pwr;
  logic       startn, stopn, door_closed, timer_zero;
  logic       timer_load, timer_en, sec_tick, mag_on, busy, done;
  logic [3:0] timer_min;
  logic [5:0] timer_sec;
  logic [1:0] stage;

  always #5 clk = ~clk;

  cook_program_scheduler #(.STAGES(STAGES), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .clear(clear), .prog_we(prog_we), .prog_idx(prog_idx),
    .prog_min(prog_min), .prog_sec(prog_sec), .prog_pwr(prog_pwr),
    .startn(startn), .stopn(stopn), .door_closed(door_closed),
    .timer_zero(timer_zero), .timer_load(timer_load), .timer_min(timer_min),
    .timer_sec(timer_sec), .timer_en(timer_en), .sec_tick(sec_tick),
    .mag_on(mag_on), .stage(stage), .busy(busy), .done(done)
  );

  // Countdown timer datapath: loads on strobe, counts down on enabled ticks.
  int t_val;
  always @(posedge clk or posedge clear) begin
    if (clear)                                  t_val <= 0;
    else if (timer_load)                        t_val <= int'(timer_min) * 60 + int'(timer_sec);
    else if (timer_en && sec_tick && t_val > 0) t_val <= t_val - 1;
  end
  assign timer_zero = (t_val == 0);

  typedef struct { bit is_done; int stg; int mn; int sc; } ev_t;
  typedef struct { bit check; int mag; int ticks; } st_t;
  ev_t ev_q[$];
  st_t st_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  pm_min[3], pm_sec[3], pm_pwr[3];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat_sec(input int s); return (s > 59) ? 59 : s; endfunction
  function automatic int sat_pwr(input int p); return (p > 10) ? 10 : p; endfunction

  // Magnetron-on cycles for one uninterrupted stage: every second s of the
  // stage is on when (s mod 10) < power, for TICK_DIV cycles, plus the one
  // extra RUN cycle in which timer_zero is sampled (second t of the window).
  function automatic int run_mag(input int t, input int p);
    int m = 0;
    for (int s = 0; s < t; s++) if ((s % 10) < p) m += TICK_DIV;
    if ((t % 10) < p) m += 1;
    return m;
  endfunction

  // Monitor state
  int mag_acc, tick_acc;
  bit in_stage, busy_d, done_d;

  task automatic close_stage();
    st_t s;
    if (st_q.size() == 0) begin
      chk("stage_stats_missing", 1, 0);
    end else begin
      s = st_q.pop_front();
      if (s.check) begin
        chk("stage_mag_cycles", mag_acc, s.mag);
        chk("stage_sec_ticks", tick_acc, s.ticks);
      end
    end
  endtask

  initial begin : monitor
    ev_t e;
    in_stage = 0; busy_d = 0; done_d = 0; mag_acc = 0; tick_acc = 0;
    forever begin
      @(negedge clk);
      if (clear) begin
        in_stage = 0; busy_d = 0; done_d = 0; mag_acc = 0; tick_acc = 0;
      end else begin
        chk("mag_safety", int'(mag_on && !(door_closed && busy && !timer_load)), 0);
        if (in_stage) begin
          mag_acc  += int'(mag_on);
          tick_acc += int'(sec_tick);
        end
        if (timer_load || (done && !done_d)) begin
          if (in_stage) close_stage();
          if (ev_q.size() == 0) begin
            chk("unexpected_event", 1, 0);
          end else begin
            e = ev_q.pop_front();
            chk("event_is_done", int'(done), int'(e.is_done));
            if (!e.is_done) begin
              chk("load_stage", int'(stage), e.stg);
              chk("load_min", int'(timer_min), e.mn);
              chk("load_sec", int'(timer_sec), e.sc);
            end
          end
          in_stage = timer_load;
          mag_acc  = 0;
          tick_acc = 0;
        end else if (busy_d && !busy && in_stage) begin
          close_stage();
          in_stage = 0;
        end
        busy_d = busy;
        done_d = done;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input int idx, input int mn, input int sc, input int pw);
    prog_we = 1'b1; prog_idx = 2'(idx); prog_min = 4'(mn); prog_sec = 6'(sc); prog_pwr = 4'(pw);
    step();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    startn = 1'b0;
    step();
    startn = 1'b1;
  endtask

  task automatic stop_to_idle();
    stopn = 1'b0;
    step();
    step();
    stopn = 1'b1;
  endtask

  task automatic push_load(input int idx, input int mn, input int sc);
    ev_q.push_back('{is_done: 1'b0, stg: idx, mn: mn, sc: sc});
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_timer_load"}, int'(timer_load), 0);
    chk({tag, "_timer_min"},  int'(timer_min), 0);
    chk({tag, "_timer_sec"},  int'(timer_sec), 0);
    chk({tag, "_timer_en"},   int'(timer_en), 0);
    chk({tag, "_sec_tick"},   int'(sec_tick), 0);
    chk({tag, "_mag_on"},     int'(mag_on), 0);
    chk({tag, "_stage"},      int'(stage), 0);
    chk({tag, "_busy"},       int'(busy), 0);
    chk({tag, "_done"},       int'(done), 0);
  endtask

  // Program pm_* into the three slots, run it to completion and leave via exit_mode.
  task automatic run_program(input int exit_mode);
    int  t, budget, waited;
    bit  any;
    for (int i = 0; i < 3; i++) write_slot(i, pm_min[i], pm_sec[i], pm_pwr[i]);
    write_slot(3, 9, $urandom_range(1, 59), 10);
    any = 0;
    budget = 20;
    for (int i = 0; i < 3; i++) begin
      t = pm_min[i] * 60 + sat_sec(pm_sec[i]);
      if (t > 0) begin
        push_load(i, pm_min[i], sat_sec(pm_sec[i]));
        st_q.push_back('{check: 1'b1, mag: run_mag(t, sat_pwr(pm_pwr[i])), ticks: t});
        budget += t * TICK_DIV + 4;
        any = 1;
      end
    end
    if (any) ev_q.push_back('{is_done: 1'b1, stg: 0, mn: 0, sc: 0});
    pulse_start();
    if (!any) begin
      step();
      step();
      chk("empty_program_refused", int'(busy), 0);
    end else begin
      waited = 0;
      while (!done && waited < budget) begin
        step();
        waited++;
      end
      chk("done_reached", int'(done), 1);
      chk("done_not_busy", int'(busy), 0);
      if (!done || exit_mode == 0) begin
        stop_to_idle();
      end else if (exit_mode == 1) begin
        door_closed = 1'b0;
        step();
        door_closed = 1'b1;
      end else begin
        pulse_start();
      end
      step();
      chk("exit_busy", int'(busy), 0);
      chk("exit_done", int'(done), 0);
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int ticks, first, sec;
    clear = 1'b1; prog_we = 1'b0; prog_idx = 2'd0; prog_min = 4'd0; prog_sec = 6'd0;
    prog_pwr = 4'd0; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
    step();
    step();
    check_outputs_zero("in_reset");
    clear = 1'b0;
    step();
    check_outputs_zero("after_reset");

    // Single stage, duty cycle and multi-stage skip programs.
    pm_min = '{0, 0, 0}; pm_sec = '{3, 0, 0};  pm_pwr = '{10, 0, 0}; run_program(0);
    pm_min = '{0, 0, 0}; pm_sec = '{20, 0, 0}; pm_pwr = '{3, 0, 0};  run_program(1);
    pm_min = '{0, 0, 0}; pm_sec = '{2, 0, 1};  pm_pwr = '{10, 7, 5}; run_program(2);

    // Door interlock with tick-count preservation across the pause.
    write_slot(0, 0, 20, 10); write_slot(1, 0, 0, 0); write_slot(2, 0, 0, 0);
    push_load(0, 0, 20);
    st_q.push_back('{check: 1'b0, mag: 0, ticks: 0});
    pulse_start();
    step();
    chk("run_mag_on", int'(mag_on), 1);
    step();
    door_closed = 1'b0;
    #1;
    chk("door_mag_same_cycle", int'(mag_on), 0);
    chk("door_cycle_still_run", int'(timer_en), 1);
    ticks = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      ticks += int'(sec_tick);
    end
    chk("pause_busy", int'(busy), 1);
    chk("pause_timer_en", int'(timer_en), 0);
    chk("pause_no_tick", ticks, 0);
    door_closed = 1'b1;
    step();
    pulse_start();
    first = -1;
    for (int k = 0; k <= TICK_DIV; k++) begin
      if (sec_tick && first < 0) first = k;
      step();
    end
    // two RUN cycles elapsed before the pause
    chk("resume_first_tick", first, TICK_DIV - 1 - (2 % TICK_DIV));
    stop_to_idle();
    chk("stop_busy", int'(busy), 0);
    chk("stop_stage", int'(stage), 0);
    push_load(0, 0, 20);
    st_q.push_back('{check: 1'b0, mag: 0, ticks: 0});
    pulse_start();
    step();
    chk("restart_running", int'(timer_en), 1);
    stop_to_idle();
    chk("restart_stop_busy", int'(busy), 0);
    door_closed = 1'b0;
    pulse_start();
    step();
    chk("door_open_refused", int'(busy), 0);
    door_closed = 1'b1;
    step();

    // Clear in the middle of RUN.
    write_slot(0, 0, 30, 7);
    push_load(0, 0, 30);
    st_q.push_back('{check: 1'b0, mag: 0, ticks: 0});
    pulse_start();
    repeat (5) step();
    chk("pre_clear_running", int'(timer_en), 1);
    clear = 1'b1;
    #1;
    check_outputs_zero("mid_run_clear");
    ev_q.delete();
    st_q.delete();
    step();
    clear = 1'b0;
    step();
    pulse_start();
    step();
    chk("erased_program_refused", int'(busy), 0);

    // Randomized programs.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 3; i++) begin
        case ($urandom_range(0, 3))
          0:       sec = 0;
          1, 2:    sec = $urandom_range(1, 12);
          default: sec = $urandom_range(55, 63);
        endcase
        pm_sec[i] = sec;
        pm_min[i] = ($urandom_range(0, 9) == 0) ? 1 : 0;
        pm_pwr[i] = $urandom_range(0, 15);
      end
      if ($urandom_range(0, 5) == 0) begin
        pm_min = '{0, 0, 0};
        pm_sec = '{0, 0, 0};
      end
      run_program($urandom_range(0, 2));
    end

    step();
    chk("events_left", ev_q.size(), 0);
    chk("stats_left", st_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
